// File: rtl/vga_sink.sv
// Purpose: VGA receiver that rebuilds pixel coordinates, data-enable and lock status from hsync/vsync/rgb pins.
// Latency: 2 clk from pin to de/x/y/pix_rgb; error pulses 2 clk after the sync edge that completes a measurement.
// Backpressure: none, because the pixel stream is free-running and every clock is consumed.
// Ports: clk, reset_n (async, active low); hsync/vsync/rgb observed pins;
//        de/x/y/pix_rgb active-pixel output; locked; line_len last line length;
//        hs_err/line_err/frame_err one-cycle error pulses; frame_count wrapping frame counter.
module vga_sink #(
  parameter int H_TOTAL     = 832,
  parameter int H_SYNC      = 40,
  parameter int H_START     = 168,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 520,
  parameter int V_START     = 31,
  parameter int V_ACTIVE    = 480,
  parameter int SYNC_LOW    = 1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [2:0]  rgb,
  output logic        de,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [2:0]  pix_rgb,
  output logic        locked,
  output logic [10:0] line_len,
  output logic        hs_err,
  output logic        line_err,
  output logic        frame_err,
  output logic [15:0] frame_count
);

  localparam logic        SYNC_POL = 1'(SYNC_LOW);
  localparam logic [11:0] H_LO     = 12'(H_START);
  localparam logic [11:0] H_HI     = 12'(H_START + H_ACTIVE);
  localparam logic [11:0] H_TOT    = 12'(H_TOTAL);
  localparam logic [10:0] H_SYN    = 11'(H_SYNC);
  localparam logic [10:0] V_LO     = 11'(V_START);
  localparam logic [10:0] V_HI     = 11'(V_START + V_ACTIVE);
  localparam logic [10:0] V_TOT    = 11'(V_TOTAL);
  localparam logic [9:0]  X_OFF    = 10'(H_START);
  localparam logic [9:0]  Y_OFF    = 10'(V_START);
  localparam logic [7:0]  LOCK_N   = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  logic        hs_q, vs_q, hs_prev, vs_prev;
  logic [2:0]  rgb_q;
  logic        hle, vle, fb, hs_fall;
  logic [10:0] hcnt, hcnt_nxt, hs_wid;
  logic [9:0]  vcnt, vcnt_nxt;
  logic        vpend, hs_seen, fb_seen;
  logic [11:0] line_meas;
  logic [10:0] frame_meas;
  logic        hs_bad_s1, line_bad_s1, frame_bad_s1, fb_s1, fb_s2;
  logic        err_seen, any_err;
  state_t      state, state_nxt;
  logic [7:0]  good, good_nxt;
  logic        de_nxt;
  logic [9:0]  x_nxt, y_nxt;

  // Syncs are normalised so 1 always means "asserted".
  assign hle        = hs_q & ~hs_prev;
  assign vle        = vs_q & ~vs_prev;
  // A frame boundary is the first line start at or after a vsync leading edge.
  assign fb         = hle & (vpend | vle);
  assign hs_fall    = ~hs_q & hs_prev & hs_seen;
  assign line_meas  = {1'b0, hcnt} + 12'd1;
  assign frame_meas = {1'b0, vcnt} + 11'd1;
  assign any_err    = hs_err | line_err | frame_err;

  // Coordinates are taken from the counter values that belong to the pixel
  // currently in rgb_q, so de/x/y/pix_rgb leave the output register together.
  assign hcnt_nxt = hle ? 11'd0 : ((hcnt == 11'h7FF) ? hcnt : hcnt + 11'd1);
  assign vcnt_nxt = fb  ? 10'd0 : ((hle && vcnt != 10'h3FF) ? vcnt + 10'd1 : vcnt);
  assign x_nxt    = hcnt_nxt[9:0] - X_OFF;
  assign y_nxt    = vcnt_nxt - Y_OFF;
  assign de_nxt   = (state_nxt == LOCKED) &&
                    ({1'b0, hcnt_nxt} >= H_LO) && ({1'b0, hcnt_nxt} < H_HI) &&
                    ({1'b0, vcnt_nxt} >= V_LO) && ({1'b0, vcnt_nxt} < V_HI);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
      rgb_q   <= '0;
    end else begin
      hs_q    <= hsync ^ SYNC_POL;
      vs_q    <= vsync ^ SYNC_POL;
      hs_prev <= hs_q;
      vs_prev <= vs_q;
      rgb_q   <= rgb;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt        <= '0;
      vcnt        <= '0;
      hs_wid      <= '0;
      hs_seen     <= 1'b0;
      vpend       <= 1'b0;
      fb_seen     <= 1'b0;
      frame_count <= '0;
      line_len    <= '0;
    end else begin
      hcnt <= hcnt_nxt;
      vcnt <= vcnt_nxt;
      if (hle)
        hs_wid <= 11'd1;
      else if (hs_q && hs_wid != 11'h7FF)
        hs_wid <= hs_wid + 11'd1;
      if (hle)
        hs_seen <= 1'b1;
      if (fb)
        vpend <= 1'b0;
      else if (vle)
        vpend <= 1'b1;
      if (fb) begin
        fb_seen     <= 1'b1;
        frame_count <= frame_count + 16'd1;
      end
      // A line that ran into saturation measures 2048, which is clamped to fit.
      if (hle && hs_seen)
        line_len <= line_meas[11] ? 11'h7FF : line_meas[10:0];
    end
  end

  // Two stages: measurement compare, then the registered error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_bad_s1    <= 1'b0;
      line_bad_s1  <= 1'b0;
      frame_bad_s1 <= 1'b0;
      fb_s1        <= 1'b0;
      hs_err       <= 1'b0;
      line_err     <= 1'b0;
      frame_err    <= 1'b0;
      fb_s2        <= 1'b0;
    end else begin
      hs_bad_s1    <= hs_fall && (hs_wid != H_SYN);
      // 2046 -> 2047 happens only once per run-up, giving a single saturation pulse.
      line_bad_s1  <= (hle && hs_seen && (line_meas != H_TOT)) ||
                      (!hle && hcnt == 11'h7FE);
      frame_bad_s1 <= fb && fb_seen && (frame_meas != V_TOT);
      fb_s1        <= fb;
      hs_err       <= hs_bad_s1;
      line_err     <= line_bad_s1;
      frame_err    <= frame_bad_s1;
      fb_s2        <= fb_s1;
    end
  end

  // The FSM sees the boundary delayed to line up with that boundary's own
  // error pulses, so the closing line/frame measurement counts toward the frame.
  always_comb begin
    state_nxt = state;
    good_nxt  = good;
    case (state)
      SEARCH: begin
        if (fb_s2) begin
          state_nxt = ACQUIRE;
          good_nxt  = '0;
        end
      end
      ACQUIRE: begin
        if (fb_s2) begin
          if (err_seen || any_err) begin
            good_nxt = '0;
          end else begin
            good_nxt = good + 8'd1;
            if ((good + 8'd1) >= LOCK_N)
              state_nxt = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (any_err)
          state_nxt = SEARCH;
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= SEARCH;
      good     <= '0;
      err_seen <= 1'b0;
    end else begin
      state <= state_nxt;
      good  <= good_nxt;
      if (fb_s2)
        err_seen <= 1'b0;
      else if (any_err)
        err_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      de      <= 1'b0;
      x       <= '0;
      y       <= '0;
      pix_rgb <= '0;
      locked  <= 1'b0;
    end else begin
      de      <= de_nxt;
      x       <= de_nxt ? x_nxt : 10'd0;
      y       <= de_nxt ? y_nxt : 10'd0;
      pix_rgb <= de_nxt ? rgb_q : 3'd0;
      locked  <= (state_nxt == LOCKED);
    end
  end

endmodule

// File: tb/tb_vga_sink.sv
module tb_vga_sink;

  localparam int HT  = 40;
  localparam int HS  = 4;
  localparam int HST = 10;
  localparam int HA  = 24;
  localparam int VT  = 20;
  localparam int VST = 4;
  localparam int VA  = 12;
  localparam int LF  = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [2:0]  rgb = 3'd0;
  logic        de;
  logic [9:0]  x, y;
  logic [2:0]  pix_rgb;
  logic        locked;
  logic [10:0] line_len;
  logic        hs_err, line_err, frame_err;
  logic [15:0] frame_count;

  vga_sink #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_START(HST), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_START(VST), .V_ACTIVE(VA), .SYNC_LOW(1), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .de(de), .x(x), .y(y), .pix_rgb(pix_rgb), .locked(locked),
    .line_len(line_len), .hs_err(hs_err), .line_err(line_err),
    .frame_err(frame_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int step_idx = 0;
  int le_cnt = 0, he_cnt = 0, fe_cnt = 0, bad_cnt = 0;
  int fr_de = 0, fr_de_idx = 0, fr_drv_idx = 0;
  bit fr_seen = 0;
  logic [9:0]  fr_fx, fr_fy, fr_lx, fr_ly;
  logic [10:0] len_at_le = '0;
  bit le_prev = 0, he_prev = 0;
  logic lock_after_le = 1'b1, lock_after_he = 1'b1;

  // Expected output for the pixels driven one and two steps ago.
  logic       p1_win = 0, p2_win = 0;
  logic [9:0] p1_x = 0, p1_y = 0, p2_x = 0, p2_y = 0;
  logic [2:0] p1_rgb = 0, p2_rgb = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One pixel clock: observe outputs, then drive the next pixel (syncs active-low on the pins).
  task automatic step(input logic hs_a, input logic vs_a, input logic [2:0] r,
                      input logic win, input logic [9:0] ex_x, input logic [9:0] ex_y);
    @(negedge clk);
    step_idx++;
    if (de) begin
      fr_de++;
      if (!fr_seen) begin
        fr_seen   = 1;
        fr_fx     = x;
        fr_fy     = y;
        fr_de_idx = step_idx;
      end
      fr_lx = x;
      fr_ly = y;
      if (!p2_win || x !== p2_x || y !== p2_y || pix_rgb !== p2_rgb)
        bad_cnt++;
    end
    if (le_prev) lock_after_le = locked;
    if (he_prev) lock_after_he = locked;
    le_prev = line_err;
    he_prev = hs_err;
    if (line_err) begin
      le_cnt++;
      len_at_le = line_len;
    end
    if (hs_err) he_cnt++;
    if (frame_err) fe_cnt++;
    p2_win = p1_win; p2_x = p1_x; p2_y = p1_y; p2_rgb = p1_rgb;
    p1_win = win;    p1_x = ex_x; p1_y = ex_y; p1_rgb = r;
    hsync = ~hs_a;
    vsync = ~vs_a;
    rgb   = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 3'd0, 1'b0, 10'd0, 10'd0);
  endtask

  task automatic send_line(input int l, input int len, input int hsw, input int vs_from);
    for (int p = 0; p < len; p++) begin
      logic w;
      w = (l >= VST) && (l < VST + VA) && (p >= HST) && (p < HST + HA);
      step(p < hsw, p >= vs_from, 3'(p + l), w, 10'(p - HST), 10'(l - VST));
      if (l == VST && p == HST) fr_drv_idx = step_idx;
    end
  endtask

  // long_l / short_l pick one line to stretch by a clock or to shorten its hsync;
  // tail raises vsync part-way through the last line so the boundary comes from the pending flag.
  task automatic send_frame(input int nlines, input int long_l, input int short_l, input bit tail);
    fr_de = 0;
    fr_seen = 0;
    for (int l = 0; l < nlines; l++) begin
      int vs_from;
      if (l < 2)                         vs_from = 0;
      else if (tail && l == nlines - 1)  vs_from = 5;
      else                               vs_from = 1 << 20;
      send_line(l, (l == long_l) ? HT + 1 : HT, (l == short_l) ? HS - 1 : HS, vs_from);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int rst_nz;
    int le0, he0, fe0;
    rst_nz = 0;

    // Reset held with toggling pins: every output must stay at zero.
    for (int i = 0; i < 20; i++) begin
      step(1'(i % 2), 1'((i / 3) % 2), 3'(i), 1'b0, 10'd0, 10'd0);
      if (de || x != 0 || y != 0 || pix_rgb != 0 || locked || line_len != 0 ||
          hs_err || line_err || frame_err || frame_count != 0)
        rst_nz++;
    end
    check_val("rst_quiet", rst_nz, 0);
    idle(4);
    reset_n = 1'b1;
    idle(6);
    check_val("rst_locked", locked, 0);
    check_val("rst_frame_count", frame_count, 0);
    check_val("rst_line_len", line_len, 0);

    // Nominal stream: boundaries at F1, F2, F3 starts; lock after the third.
    send_frame(VT, -1, -1, 0);
    send_frame(VT, -1, -1, 0);
    check_val("unlocked_f2", locked, 0);
    send_frame(VT, -1, -1, 0);
    check_val("locked_f3", locked, 1);
    check_val("de_cnt_f3", fr_de, HA * VA);
    check_val("first_x", fr_fx, 0);
    check_val("first_y", fr_fy, 0);
    check_val("first_de_latency", fr_de_idx - fr_drv_idx, 2);
    check_val("last_x", fr_lx, HA - 1);
    check_val("last_y", fr_ly, VA - 1);
    send_frame(VT, -1, -1, 0);
    check_val("de_cnt_f4", fr_de, HA * VA);
    check_val("line_len_nom", line_len, HT);
    check_val("frame_count_f4", frame_count, 4);
    check_val("nom_line_err", le_cnt, 0);
    check_val("nom_hs_err", he_cnt, 0);
    check_val("nom_frame_err", fe_cnt, 0);

    // Long line while locked.
    le0 = le_cnt;
    send_frame(VT, 7, -1, 0);
    check_val("long_line_err_cnt", le_cnt - le0, 1);
    check_val("long_line_len", len_at_le, HT + 1);
    check_val("long_unlock", lock_after_le, 0);
    send_frame(VT, -1, -1, 0);
    send_frame(VT, -1, -1, 0);
    check_val("long_still_unlocked", locked, 0);
    send_frame(VT, -1, -1, 0);
    check_val("long_relocked", locked, 1);
    check_val("de_cnt_relock", fr_de, HA * VA);

    // Short hsync while locked.
    le0 = le_cnt;
    he0 = he_cnt;
    send_frame(VT, -1, 3, 0);
    check_val("short_hs_err_cnt", he_cnt - he0, 1);
    check_val("short_hs_no_line_err", le_cnt - le0, 0);
    check_val("short_hs_unlock", lock_after_he, 0);
    send_frame(VT, -1, -1, 0);
    send_frame(VT, -1, -1, 0);
    check_val("short_hs_still_unlocked", locked, 0);

    // Relock frame ending with a mid-line vsync; next frame starts via the pending flag.
    fe0 = fe_cnt;
    send_frame(VT, -1, -1, 1);
    check_val("tail_locked", locked, 1);
    send_frame(VT - 1, -1, -1, 0);
    check_val("pend_no_frame_err", fe_cnt - fe0, 0);
    check_val("pend_de_cnt", fr_de, HA * VA);
    check_val("pend_first_y", fr_fy, 0);
    check_val("pend_first_x", fr_fx, 0);
    check_val("pend_locked", locked, 1);

    // Short frame detected at the next boundary.
    send_frame(VT, -1, -1, 0);
    check_val("short_frame_err_cnt", fe_cnt - fe0, 1);
    check_val("short_frame_unlock", locked, 0);

    // Missing hsync: counter saturates with a single error.
    le0 = le_cnt;
    idle(3000);
    check_val("sat_line_err_cnt", le_cnt - le0, 1);
    check_val("sat_hcnt", dut.hcnt, 2047);

    // Reset in the middle of a frame clears everything at once.
    for (int l = 0; l < 6; l++)
      send_line(l, HT, HS, (l < 2) ? 0 : (1 << 20));
    reset_n = 1'b0;
    #1;
    check_val("midrst_frame_count", frame_count, 0);
    check_val("midrst_line_len", line_len, 0);
    check_val("midrst_others", {de, x, y, pix_rgb, locked, hs_err, line_err, frame_err}, 0);
    idle(3);
    reset_n = 1'b1;
    for (int l = 6; l < VT; l++)
      send_line(l, HT, HS, 1 << 20);
    send_frame(VT, -1, -1, 0);
    send_frame(VT, -1, -1, 0);
    check_val("midrst_unlocked", locked, 0);
    send_frame(VT, -1, -1, 0);
    check_val("midrst_relocked", locked, 1);
    check_val("midrst_frame_count_after", frame_count, 3);

    check_val("de_pixel_mismatches", bad_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_sink.md
# vga_sink

Pixel-clock-domain VGA receiver for the starfield video path. It samples the `hsync`/`vsync`/`rgb` stream the generator drives to the pins and rebuilds pixel coordinates and a data-enable from it. It also measures sync width, line length and frame length, and reports lock and timing errors. Used as an on-chip loopback checker and as the observation end of the simulation bench, on the same `clk` as the generator.

## Interface
- `H_TOTAL`, 832: expected pixel clocks per line.
- `H_SYNC`, 40: expected hsync asserted width in clocks.
- `H_START`, 168: clocks from hsync leading edge to first active pixel.
- `H_ACTIVE`, 640: active pixels per line.
- `V_TOTAL`, 520: expected lines per frame.
- `V_START`, 31: lines from vsync-aligned line 0 to first active line.
- `V_ACTIVE`, 480: active lines per frame.
- `SYNC_LOW`, 1: 1 = syncs active-low, 0 = active-high.
- `LOCK_FRAMES`, 2: consecutive error-free frames required for lock.

Ports:
- `clk`  in  1  pixel clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `hsync`  in  1  observed horizontal sync.
- `vsync`  in  1  observed vertical sync.
- `rgb`  in  3  observed colour.
- `de`  out  1  active-pixel strobe, only when locked.
- `x`  out  10  active column, 0..H_ACTIVE-1. Valid when `de`.
- `y`  out  10  active row, 0..V_ACTIVE-1. Valid when `de`.
- `pix_rgb`  out  3  colour aligned with `de`/`x`/`y`.
- `locked`  out  1  lock FSM in LOCKED.
- `line_len`  out  11  last measured line length.
- `hs_err`  out  1  one-cycle pulse: hsync width differs from `H_SYNC`.
- `line_err`  out  1  one-cycle pulse: line length differs from `H_TOTAL`, or the counter saturated.
- `frame_err`  out  1  one-cycle pulse: frame lines differ from `V_TOTAL`.
- `frame_count`  out  16  wrapping count of completed frames.

## Operation
- **Input stage**
  - Inputs are registered once (`hs_q`, `vs_q`, `rgb_q`); polarity is normalised so "asserted" means the sync is active.
  - HLE (hsync leading edge): `hs_q` asserted and its previous value deasserted. VLE is the same for `vsync`.
- **Horizontal counter `hcnt` (11 bit)**
  - On HLE it loads 0. Otherwise it increments, saturating at 2047.
  - The first time it saturates, raise `line_err`.
  - On HLE, `line_len` ← previous `hcnt`+1. If that value ≠ `H_TOTAL`, raise `line_err`.
  - The first HLE after reset only loads the counter; it produces no measurement and no error.
- **Sync width**
  - Count asserted `hs_q` cycles.
  - On hsync deassertion, compare the count with `H_SYNC`; on mismatch raise `hs_err`.
- **Vertical counter `vcnt` (10 bit)**
  - Increments on each HLE.
  - VLE sets `vpend`. On the next HLE, or on the same cycle if VLE and HLE coincide:
    - frame lines = `vcnt`+1 is compared with `V_TOTAL`, raising `frame_err` on mismatch;
    - `vcnt` loads 0, `vpend` clears and `frame_count` increments.
  - The first frame boundary after reset produces no comparison.
- **Lock FSM**
  - SEARCH: on the first frame boundary → ACQUIRE, with good-frame counter = 0.
  - ACQUIRE: at each frame boundary, if no error occurred during the frame, the counter increments; otherwise it resets to 0. When the counter reaches `LOCK_FRAMES` → LOCKED.
  - LOCKED: any `hs_err`, `line_err` or `frame_err` → SEARCH.
- **Outputs**
  - `de` = LOCKED and `H_START` ≤ `hcnt` < `H_START`+`H_ACTIVE` and `V_START` ≤ `vcnt` < `V_START`+`V_ACTIVE`.
  - `x` = `hcnt`−`H_START` and `y` = `vcnt`−`V_START`, truncated to 10 bits.
  - `pix_rgb` = `rgb_q`.
  - All outputs are registered.
  - When `de` is 0, `x`, `y` and `pix_rgb` are held at 0.

## Timing
- All outputs are reset to 0: `de`, `x`, `y`, `pix_rgb`, `locked`, `line_len`, every error pulse and `frame_count`. Reset also clears all counters and `vpend`, and returns the FSM to SEARCH.
- Latency from a pin to the corresponding `de`/`x`/`y`/`pix_rgb` is 2 cycles: the input register plus the output register.
- An `hsync` leading edge sampled at edge *n* gives `hcnt`=0 at edge *n*+1. Error pulses appear at edge *n*+2.
- `locked` rises in the cycle after the qualifying frame boundary. It falls in the cycle after the error pulse, and `de` is 0 from that same cycle.
- Reset asserted mid-frame clears everything immediately. After release, the block needs one full unmeasured frame plus `LOCK_FRAMES` good frames before it locks.

## Test plan
- **Reset:** hold `reset_n`=0 with toggling inputs → all outputs stay 0. Release → `locked`=0.
- **Nominal stream:** drive 4 frames at 832×520 with a 40-clock hsync and a 2-line vsync → `locked` rises after the frame-3 boundary. Then:
  - first `de` has `x`=0 and `y`=0, 2 cycles after the pin pixel at `hcnt`=168, `vcnt`=31;
  - last `de` has `x`=639 and `y`=479;
  - exactly 307200 `de` per frame;
  - `line_len`=832.
- **Long line:** while locked, make one line 833 clocks → one `line_err` pulse, `line_len`=833, `locked`=0 next cycle, relock after 2 good frames.
- **Short hsync:** give one hsync a 39-clock width → one `hs_err` pulse; `line_err` stays 0.
- **Short frame:** drive a 519-line frame → `frame_err` at that boundary and the FSM returns to SEARCH. Also drive VLE on the same cycle as HLE → `vcnt`=0 at that line, with no extra line counted.
- **Missing hsync:** hold hsync deasserted for 3000 clocks → a single `line_err` at saturation and `hcnt` held at 2047. Then assert `reset_n`=0 mid-frame → immediate clear.
